// File: rtl/mem_wb_pipe.sv
// mem_wb_pipe -- parameterised MEM/WB pipeline register.
//
// Holds one instruction slot between the MEM stage and the register-file
// write port. It supports stall (hold) and flush (bubble). The write-back
// data mux and the final register-file write enable are registered here, so
// the forwarding unit and the register file read plain flop outputs. No input
// reaches an output combinationally.
//
// Optional feature: define MEM_WB_PERF_CNT_EN to add the retire_cnt and
// bubble_cnt performance counters.
//
// Ports:
//   clk, rst_n        clock; asynchronous active-low reset clears all outputs
//   stall             hold every register this edge
//   flush             load a bubble this edge (wins over stall)
//   in_valid          MEM stage holds a real instruction
//   control_wb_in     WB control bundle (RegWrite / MemtoReg plus pass-through bits)
//   Read_data_in      data memory read data
//   ALU_result_in     ALU result
//   Write_reg_in      destination register index
//   wb_valid          slot holds a real instruction
//   mem_control_wb, Read_data, mem_ALU_result, mem_Write_reg  registered copies
//   wb_write_data     registered MemtoReg ? read data : ALU result
//   wb_reg_write      registered RegWrite qualified by valid and a nonzero destination
//   retire_cnt        (optional) count of loaded register-file writes
//   bubble_cnt        (optional) count of bubbles inserted by flush or by an invalid load
module mem_wb_pipe #(
  parameter int DATA_W       = 32,
  parameter int REG_W        = 5,
  parameter int CTRL_W       = 2,
  parameter int REGWRITE_BIT = 0,
  parameter int MEMTOREG_BIT = 1,
  parameter int CNT_W        = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              in_valid,
  input  logic [CTRL_W-1:0] control_wb_in,
  input  logic [DATA_W-1:0] Read_data_in,
  input  logic [DATA_W-1:0] ALU_result_in,
  input  logic [REG_W-1:0]  Write_reg_in,
`ifdef MEM_WB_PERF_CNT_EN
  output logic [CNT_W-1:0]  retire_cnt,
  output logic [CNT_W-1:0]  bubble_cnt,
`endif
  output logic              wb_valid,
  output logic [CTRL_W-1:0] mem_control_wb,
  output logic [DATA_W-1:0] Read_data,
  output logic [DATA_W-1:0] mem_ALU_result,
  output logic [REG_W-1:0]  mem_Write_reg,
  output logic [DATA_W-1:0] wb_write_data,
  output logic              wb_reg_write
);

  typedef struct packed {
    logic [CTRL_W-1:0] ctrl;
    logic [DATA_W-1:0] rd;
    logic [DATA_W-1:0] alu;
    logic [REG_W-1:0]  wr;
    logic [DATA_W-1:0] wd;
    logic              rw;
  } wb_slot_t;

  wb_slot_t slot_d, slot_q;
  logic     vld_q;

  // The slot to load on a normal edge. A dead slot (in_valid = 0) is all
  // zeros, which keeps its control bits from ever causing a write.
  always_comb begin
    slot_d = '0;
    if (in_valid) begin
      slot_d.ctrl = control_wb_in;
      slot_d.rd   = Read_data_in;
      slot_d.alu  = ALU_result_in;
      slot_d.wr   = Write_reg_in;
      slot_d.wd   = control_wb_in[MEMTOREG_BIT] ? Read_data_in : ALU_result_in;
      // A write to r0 is dropped here, but mem_Write_reg still shows 0.
      slot_d.rw   = control_wb_in[REGWRITE_BIT] & (Write_reg_in != '0);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_q <= '0;
      vld_q  <= 1'b0;
    end else if (flush) begin
      slot_q <= '0;
      vld_q  <= 1'b0;
    end else if (!stall) begin
      slot_q <= slot_d;
      vld_q  <= in_valid;
    end
  end

  assign wb_valid       = vld_q;
  assign mem_control_wb = slot_q.ctrl;
  assign Read_data      = slot_q.rd;
  assign mem_ALU_result = slot_q.alu;
  assign mem_Write_reg  = slot_q.wr;
  assign wb_write_data  = slot_q.wd;
  assign wb_reg_write   = slot_q.rw;

`ifdef MEM_WB_PERF_CNT_EN
  logic retire_inc, bubble_inc;
  assign retire_inc = !flush && !stall && slot_d.rw;
  assign bubble_inc = flush || (!stall && !in_valid);

  // Both counters wrap naturally at 2^CNT_W.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retire_cnt <= '0;
      bubble_cnt <= '0;
    end else begin
      if (retire_inc) retire_cnt <= retire_cnt + 1'b1;
      if (bubble_inc) bubble_cnt <= bubble_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_mem_wb_pipe.sv
module tb_mem_wb_pipe;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0, flush = 1'b0, in_valid = 1'b0;
  logic [1:0]  control_wb_in = '0;
  logic [31:0] Read_data_in = '0, ALU_result_in = '0;
  logic [4:0]  Write_reg_in = '0;

  logic        wb_valid, wb_reg_write;
  logic [1:0]  mem_control_wb;
  logic [31:0] Read_data, mem_ALU_result, wb_write_data;
  logic [4:0]  mem_Write_reg;

  int checks = 0;
  int failures = 0;
  int exp_ret = 0, exp_bub = 0;

  always #5 clk = ~clk;

`ifdef MEM_WB_PERF_CNT_EN
  logic [31:0] retire_cnt, bubble_cnt;
  logic [1:0]  retire_cnt2, bubble_cnt2;
  logic        v2, rw2;
  logic [1:0]  c2;
  logic [31:0] rd2, alu2, wd2;
  logic [4:0]  wr2;

  // Narrow-counter copy, used to check wrap-around.
  mem_wb_pipe #(.CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .control_wb_in(control_wb_in), .Read_data_in(Read_data_in),
    .ALU_result_in(ALU_result_in), .Write_reg_in(Write_reg_in),
    .retire_cnt(retire_cnt2), .bubble_cnt(bubble_cnt2),
    .wb_valid(v2), .mem_control_wb(c2), .Read_data(rd2), .mem_ALU_result(alu2),
    .mem_Write_reg(wr2), .wb_write_data(wd2), .wb_reg_write(rw2)
  );
`endif

  mem_wb_pipe u_dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .in_valid(in_valid),
    .control_wb_in(control_wb_in), .Read_data_in(Read_data_in),
    .ALU_result_in(ALU_result_in), .Write_reg_in(Write_reg_in),
`ifdef MEM_WB_PERF_CNT_EN
    .retire_cnt(retire_cnt), .bubble_cnt(bubble_cnt),
`endif
    .wb_valid(wb_valid), .mem_control_wb(mem_control_wb), .Read_data(Read_data),
    .mem_ALU_result(mem_ALU_result), .mem_Write_reg(mem_Write_reg),
    .wb_write_data(wb_write_data), .wb_reg_write(wb_reg_write)
  );

  typedef struct {
    logic        st, fl, v;
    logic [1:0]  ctrl;
    logic [31:0] rd, alu;
    logic [4:0]  wr;
    logic        e_v;
    logic [1:0]  e_ctrl;
    logic [31:0] e_rd, e_alu;
    logic [4:0]  e_wr;
    logic [31:0] e_wd;
    logic        e_rw;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_outs(input string tag, input logic ev, input logic [1:0] ec,
                          input logic [31:0] erd, input logic [31:0] ealu,
                          input logic [4:0] ewr, input logic [31:0] ewd, input logic erw);
    chk({tag, ".wb_valid"},       {31'b0, wb_valid},       {31'b0, ev});
    chk({tag, ".mem_control_wb"}, {30'b0, mem_control_wb}, {30'b0, ec});
    chk({tag, ".Read_data"},      Read_data,               erd);
    chk({tag, ".mem_ALU_result"}, mem_ALU_result,          ealu);
    chk({tag, ".mem_Write_reg"},  {27'b0, mem_Write_reg},  {27'b0, ewr});
    chk({tag, ".wb_write_data"},  wb_write_data,           ewd);
    chk({tag, ".wb_reg_write"},   {31'b0, wb_reg_write},   {31'b0, erw});
  endtask

  // Reference counter model, advanced once per applied edge.
  task automatic model_edge();
    if (flush) exp_bub++;
    else if (!stall) begin
      if (!in_valid) exp_bub++;
      else if (control_wb_in[0] && Write_reg_in != 5'd0) exp_ret++;
    end
  endtask

  initial begin
    //            st  fl  v   ctrl   rd            alu           wr     e_v e_ctrl e_rd          e_alu         e_wr   e_wd          e_rw
    vecs[0]  = '{1'b0,1'b0,1'b1,2'b01,32'hFF00AAD0,32'h00ADAD10,5'd3,  1'b1,2'b01,32'hFF00AAD0,32'h00ADAD10,5'd3,  32'h00ADAD10,1'b1};
    vecs[1]  = '{1'b0,1'b0,1'b1,2'b11,32'hDEADBEEF,32'h12345678,5'd7,  1'b1,2'b11,32'hDEADBEEF,32'h12345678,5'd7,  32'hDEADBEEF,1'b1};
    vecs[2]  = '{1'b0,1'b0,1'b1,2'b01,32'h11111111,32'h22222222,5'd0,  1'b1,2'b01,32'h11111111,32'h22222222,5'd0,  32'h22222222,1'b0};
    vecs[3]  = '{1'b0,1'b0,1'b1,2'b01,32'hAAAA0000,32'h0000BBBB,5'd9,  1'b1,2'b01,32'hAAAA0000,32'h0000BBBB,5'd9,  32'h0000BBBB,1'b1};
    vecs[4]  = '{1'b1,1'b0,1'b1,2'b10,32'hCAFE0001,32'h00000C0C,5'd12, 1'b1,2'b01,32'hAAAA0000,32'h0000BBBB,5'd9,  32'h0000BBBB,1'b1};
    vecs[5]  = vecs[4];
    vecs[6]  = vecs[4];
    vecs[7]  = '{1'b0,1'b0,1'b1,2'b10,32'hCAFE0001,32'h00000C0C,5'd12, 1'b1,2'b10,32'hCAFE0001,32'h00000C0C,5'd12, 32'hCAFE0001,1'b0};
    vecs[8]  = '{1'b0,1'b0,1'b0,2'b01,32'h55555555,32'h66666666,5'd5,  1'b0,2'b00,32'h0,        32'h0,        5'd0,  32'h0,        1'b0};
    vecs[9]  = '{1'b0,1'b0,1'b1,2'b01,32'h00000000,32'h00000044,5'd4,  1'b1,2'b01,32'h0,        32'h00000044,5'd4,  32'h00000044,1'b1};
    vecs[10] = '{1'b1,1'b1,1'b1,2'b11,32'h00000001,32'h00000002,5'd8,  1'b0,2'b00,32'h0,        32'h0,        5'd0,  32'h0,        1'b0};
    vecs[11] = '{1'b0,1'b0,1'b1,2'b11,32'h1F1F1F1F,32'h00000005,5'd31, 1'b1,2'b11,32'h1F1F1F1F,32'h00000005,5'd31, 32'h1F1F1F1F,1'b1};
    vecs[12] = '{1'b0,1'b0,1'b1,2'b00,32'h00000006,32'h00000060,5'd6,  1'b1,2'b00,32'h00000006,32'h00000060,5'd6,  32'h00000060,1'b0};

    // Reset held with nonzero inputs across several edges.
    in_valid = 1'b1; control_wb_in = 2'b11; Read_data_in = 32'hA5A5A5A5;
    ALU_result_in = 32'h5A5A5A5A; Write_reg_in = 5'd17;
    repeat (3) @(posedge clk);
    #1;
    chk_outs("reset", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
`ifdef MEM_WB_PERF_CNT_EN
    chk("reset.retire_cnt", retire_cnt, 32'd0);
    chk("reset.bubble_cnt", bubble_cnt, 32'd0);
`endif
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) begin
      stall = vecs[i].st; flush = vecs[i].fl; in_valid = vecs[i].v;
      control_wb_in = vecs[i].ctrl; Read_data_in = vecs[i].rd;
      ALU_result_in = vecs[i].alu; Write_reg_in = vecs[i].wr;
      model_edge();
      @(posedge clk);
      #1;
      chk_outs($sformatf("vec%0d", i), vecs[i].e_v, vecs[i].e_ctrl, vecs[i].e_rd,
               vecs[i].e_alu, vecs[i].e_wr, vecs[i].e_wd, vecs[i].e_rw);
    end
`ifdef MEM_WB_PERF_CNT_EN
    chk("table.retire_cnt", retire_cnt, exp_ret);
    chk("table.bubble_cnt", bubble_cnt, exp_bub);
    chk("table.retire_cnt2", {30'b0, retire_cnt2}, exp_ret % 4);
`endif

    // Asynchronous reset in mid-cycle, with a stall in progress.
    stall = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk_outs("async_rst", 1'b0, 2'b00, 32'h0, 32'h0, 5'd0, 32'h0, 1'b0);
`ifdef MEM_WB_PERF_CNT_EN
    chk("async_rst.retire_cnt", retire_cnt, 32'd0);
    chk("async_rst.bubble_cnt", bubble_cnt, 32'd0);
`endif
    #2 rst_n = 1'b1;

    // Five retires in a row: the 2-bit counter wraps to 1.
    stall = 1'b0; flush = 1'b0; in_valid = 1'b1; control_wb_in = 2'b01;
    Read_data_in = 32'h0; ALU_result_in = 32'h00000077; Write_reg_in = 5'd1;
    repeat (5) @(posedge clk);
    #1;
    chk_outs("retire5", 1'b1, 2'b01, 32'h0, 32'h00000077, 5'd1, 32'h00000077, 1'b1);
`ifdef MEM_WB_PERF_CNT_EN
    chk("retire5.retire_cnt", retire_cnt, 32'd5);
    chk("retire5.retire_cnt2", {30'b0, retire_cnt2}, 32'd1);
    chk("retire5.bubble_cnt", bubble_cnt, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
